dram256_arbiter: RTL and testbench

- Two-requester controller wrapping one RAM256X1S (256x1, async read, sync write on WCLK) shared between requesters A and B.
- Arbitrates with a round-robin pointer and returns registered read data.
- Runs a clear sequencer after reset, or on demand, that writes CLEAR_VALUE to all 256 locations; distributed-RAM contents are not reset by rst.
- Sits between fabric logic (switch/UART-driven test harnesses) and the DRAM primitive in feature tests.

---
 rtl/dram256_arbiter.sv | 136 +++++++++++++
 tb/tb_dram256_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram256_arbiter.sv
// Round-robin arbiter for two requesters sharing one 256x1 distributed RAM,
// with a clear sequencer that fills the RAM after reset or on request.
module dram256_arbiter #(
  parameter logic [255:0] INIT           = 256'h0,
  parameter bit           CLEAR_ON_RESET = 1'b1,
  parameter logic         CLEAR_VALUE    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_req,
  output logic       busy,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic       a_wdata,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic       a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic       b_wdata,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic       b_rdata
);

  typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;

  state_t       state, state_next;
  logic [7:0]   cnt, cnt_next;
  logic         ptr, ptr_next;      // 0 favours A, 1 favours B
  logic [255:0] mem = INIT;         // RAM contents survive rst
  logic         ram_we;
  logic [7:0]   ram_addr;
  logic         ram_d;
  logic         ram_o;

  assign ram_o = mem[ram_addr];
  assign busy  = (state == CLEAR);

  // Next-state, grant and RAM port selection.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ptr_next   = ptr;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = a_addr;
    ram_d      = a_wdata;
    if (rst) begin
      a_gnt  = 1'b0;
      b_gnt  = 1'b0;
      ram_we = 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          ram_we   = 1'b1;
          ram_addr = cnt;
          ram_d    = CLEAR_VALUE;
          cnt_next = cnt + 8'd1;
          if (cnt == 8'd255) begin
            state_next = SERVE;
          end else begin
            state_next = CLEAR;
          end
        end
        SERVE: begin
          if (clear_req) begin
            state_next = CLEAR;
            cnt_next   = 8'd0;
          end else begin
            a_gnt = a_req & (~b_req | ~ptr);
            b_gnt = b_req & (~a_req | ptr);
            if (b_gnt) begin
              ram_we   = b_we;
              ram_addr = b_addr;
              ram_d    = b_wdata;
              ptr_next = 1'b0;
            end else if (a_gnt) begin
              ram_we   = a_we;
              ram_addr = a_addr;
              ram_d    = a_wdata;
              ptr_next = 1'b1;
            end else begin
              ram_we = 1'b0;
            end
          end
        end
        default: begin
          state_next = SERVE;
        end
      endcase
    end
  end

  // Control state, pointer and registered read returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RESET ? CLEAR : SERVE;
      cnt      <= 8'd0;
      ptr      <= 1'b0;
      a_rvalid <= 1'b0;
      a_rdata  <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ptr      <= ptr_next;
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) begin
        a_rdata <= ram_o;
      end else begin
        a_rdata <= a_rdata;
      end
      if (b_gnt && !b_we) begin
        b_rdata <= ram_o;
      end else begin
        b_rdata <= b_rdata;
      end
    end
  end

  // Synchronous write port of the distributed RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_d;
    end else begin
      mem <= mem;
    end
  end

endmodule

// File: tb/tb_dram256_arbiter.sv
// Randomized and directed bench for dram256_arbiter, checked every cycle
// against a transaction-level model of the shared RAM and arbiter.
module tb_dram256_arbiter;

  logic       clk = 1'b0;
  logic       rst, clear_req, busy;
  logic       a_req, a_we, a_wdata, a_gnt, a_rvalid, a_rdata;
  logic       b_req, b_we, b_wdata, b_gnt, b_rvalid, b_rdata;
  logic [7:0] a_addr, b_addr;

  int checks = 0;
  int errors = 0;

  dram256_arbiter #(
    .INIT({256{1'b1}}),
    .CLEAR_ON_RESET(1'b1),
    .CLEAR_VALUE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: RAM as a bit array, clear as a countdown of pending writes.
  bit       m_known = 1'b0;
  bit       m_mem [256];
  int       m_left;
  bit       m_ptr_b;
  bit       m_arv, m_ard, m_brv, m_brd;

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 1'b1;
  end

  always @(negedge clk) begin
    bit ea, eb, narv, nbrv;
    if (rst) begin
      if (m_known) begin
        chk("gnt_a_in_rst", {31'd0, a_gnt}, 32'd0);
        chk("gnt_b_in_rst", {31'd0, b_gnt}, 32'd0);
      end
      m_known = 1'b1;
      m_left  = 256;
      m_ptr_b = 1'b0;
      m_arv = 1'b0; m_ard = 1'b0; m_brv = 1'b0; m_brd = 1'b0;
    end else if (m_known) begin
      ea = 1'b0;
      eb = 1'b0;
      if (m_left == 0 && !clear_req) begin
        if (a_req && b_req) begin
          ea = !m_ptr_b;
          eb = m_ptr_b;
        end else begin
          ea = a_req;
          eb = b_req;
        end
      end
      chk("busy",     {31'd0, busy},     {31'd0, m_left > 0});
      chk("a_gnt",    {31'd0, a_gnt},    {31'd0, ea});
      chk("b_gnt",    {31'd0, b_gnt},    {31'd0, eb});
      chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, m_arv});
      chk("a_rdata",  {31'd0, a_rdata},  {31'd0, m_ard});
      chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, m_brv});
      chk("b_rdata",  {31'd0, b_rdata},  {31'd0, m_brd});
      if (m_left > 0) begin
        m_mem[256 - m_left] = 1'b0;
        m_left--;
      end else if (clear_req) begin
        m_left = 256;
      end
      narv = ea && !a_we;
      nbrv = eb && !b_we;
      if (ea) begin
        m_ptr_b = 1'b1;
        if (a_we) m_mem[a_addr] = a_wdata;
        else m_ard = m_mem[a_addr];
      end
      if (eb) begin
        m_ptr_b = 1'b0;
        if (b_we) m_mem[b_addr] = b_wdata;
        else m_brd = m_mem[b_addr];
      end
      m_arv = narv;
      m_brv = nbrv;
    end
  end

  task automatic op(input logic r, input logic clr,
                    input logic ar, input logic aw, input logic [7:0] aa, input logic ad,
                    input logic br, input logic bw, input logic [7:0] ba, input logic bd);
    @(posedge clk);
    #1;
    rst = r; clear_req = clr;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
  endtask

  // Counts busy cycles from the current one, inputs held, no grants allowed.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      n++;
      chk("busy_no_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic ah, bh;
    rst = 1'b1; clear_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00; a_wdata = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 1'b0;
    repeat (3) @(posedge clk);

    // Clear after reset, A keeps requesting a read of 0x00.
    op(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    count_busy(n);
    chk("reset_clear_len", n, 32'd256);
    chk("first_gnt", {31'd0, a_gnt}, 32'd1);
    op(1'b0, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rd00_valid", {31'd0, a_rvalid}, 32'd1);
    chk("rd00_data",  {31'd0, a_rdata},  32'd0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rd7f_data",  {31'd0, a_rdata},  32'd0);
    op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rdff_valid", {31'd0, a_rvalid}, 32'd1);
    chk("rdff_data",  {31'd0, a_rdata},  32'd0);

    // Read-after-write across requesters.
    op(1'b0, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("raw_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("idle_rvalid", {31'd0, a_rvalid}, 32'd0);
    op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h2A, 1'b0);
    chk("raw_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("wr_no_rvalid", {31'd0, a_rvalid}, 32'd0);
    op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("raw_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("raw_b_rdata",  {31'd0, b_rdata},  32'd1);

    // Contention alternates starting with A.
    for (int i = 0; i < 6; i++) begin
      op(1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0, 8'h2A, 1'b0);
      chk("alt_a_gnt", {31'd0, a_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_b_gnt", {31'd0, b_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) chk("alt_a_rvalid", {31'd0, a_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("alt_last_rvalid", {31'd0, b_rvalid}, 32'd1);

    // Only B requests, then contention goes to A.
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'(i + 5), 1'b0);
      chk("b_only_gnt", {31'd0, b_gnt}, 32'd1);
    end
    op(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0);
    chk("after_b_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("after_b_b_gnt", {31'd0, b_gnt}, 32'd0);

    // On-demand clear with a read in flight.
    op(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_clr_gnt", {31'd0, a_gnt}, 32'd1);
    op(1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("clr_no_gnt", {31'd0, a_gnt}, 32'd0);
    chk("clr_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("clr_rdata",  {31'd0, a_rdata},  32'd1);
    op(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    count_busy(n);
    chk("req_clear_len", n, 32'd256);
    op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("post_clr_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("post_clr_rdata",  {31'd0, a_rdata},  32'd0);

    // Reset in the middle of a clear restarts it.
    op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 100; i++)
      op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    op(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    count_busy(n);
    chk("rst_mid_clear_len", n, 32'd256);

    // Randomized traffic; a pending request is held until granted.
    ah = 1'b0;
    bh = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 599) == 0);
      clear_req = ($urandom_range(0, 199) == 0);
      if (!ah) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_we = $urandom_range(0, 1);
        a_addr = 8'($urandom_range(0, 15));
        a_wdata = $urandom_range(0, 1);
      end
      if (!bh) begin
        b_req = ($urandom_range(0, 3) != 0);
        b_we = $urandom_range(0, 1);
        b_addr = 8'($urandom_range(0, 15));
        b_wdata = $urandom_range(0, 1);
      end
      @(negedge clk);
      ah = a_req && !a_gnt && !rst;
      bh = b_req && !b_gnt && !rst;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
